// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the Dino game run-state controller
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_e;

  // Five packed BCD digits, [3:0] = ones
  typedef logic [19:0] bcd5_t;

  localparam int unsigned SPAWN_X_DEF = 640;
  localparam bcd5_t       BCD5_MAX    = 20'h99999;

  // Feedback taps for x^7 + x^6 + 1 (bits 6 and 5 of the state)
  localparam logic [6:0]  LFSR_TAPS   = 7'h60;

  // One Fibonacci step: shift left, feed the XOR of the tapped bits into bit 0
  function automatic logic [6:0] lfsr7_step(input logic [6:0] s);
    return {s[5:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter5.sv
// rtl/bcd_counter5.sv - five-digit saturating BCD counter with carry-into-hundreds flag
module bcd_counter5
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clr_i,
  input  logic  inc_i,
  output bcd5_t cnt_o,
  output logic  carry_hundreds_o
);

  bcd5_t cnt_q, cnt_d;
  logic  sat;
  logic  ripple;

  assign sat   = (cnt_q == BCD5_MAX);
  assign cnt_o = cnt_q;

  // Flags that the next increment will roll the tens digit into the hundreds digit.
  // Kept independent of inc_i so callers can gate it without a combinational loop.
  assign carry_hundreds_o = (cnt_q[7:0] == 8'h99) && !sat;

  // Next count: clear wins, otherwise ripple +1 through the digits unless saturated
  always_comb begin
    cnt_d  = cnt_q;
    ripple = 1'b1;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat) begin
      for (int i = 0; i < 5; i++) begin
        if (ripple) begin
          if (cnt_q[4*i +: 4] == 4'd9) begin
            cnt_d[4*i +: 4] = 4'd0;
          end else begin
            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
            ripple          = 1'b0;
          end
        end
      end
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - Dino game run-state FSM, score, high score, cactus scroll and speed ramp
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned SPAWN_X     = SPAWN_X_DEF,
  parameter int unsigned SCORE_DIV   = 2,
  parameter int unsigned SPEED_INIT  = 1,
  parameter int unsigned SPEED_MAX   = 6,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter logic [6:0]  LFSR_SEED   = 7'h5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        collision,
  output logic        game_on,
  output logic        game_over,
  output logic [9:0]  cacti_x,
  output logic [19:0] score_bcd,
  output logic [19:0] high_bcd,
  output logic        new_high,
  output logic [2:0]  speed
);

  localparam logic [9:0] SPAWN_L   = 10'(SPAWN_X);
  localparam logic [7:0] DIV_LAST  = 8'(SCORE_DIV - 1);
  localparam logic [2:0] SPD_INIT  = 3'(SPEED_INIT);
  localparam logic [2:0] SPD_MAX   = 3'(SPEED_MAX);
  localparam logic [7:0] HOLD_L    = 8'(HOLD_FRAMES);

  game_state_e state_q, state_d;
  logic [9:0]  cacti_q, cacti_d;
  logic [2:0]  speed_q, speed_d;
  logic [7:0]  div_q, div_d;
  logic [6:0]  lfsr_q, lfsr_d;
  logic [7:0]  hold_q, hold_d;
  bcd5_t       high_q, high_d;
  logic        new_high_q, new_high_d;
  logic        start_meta_q, start_sync_q, start_prev_q;
  logic        start_pulse;
  logic        score_clr, score_inc;
  logic        score_carry;
  bcd5_t       score;

  assign start_pulse = start_sync_q & ~start_prev_q;

  bcd_counter5 u_score (
    .clk              (clk),
    .reset            (reset),
    .clr_i            (score_clr),
    .inc_i            (score_inc),
    .cnt_o            (score),
    .carry_hundreds_o (score_carry)
  );

  // Two-flop synchroniser on the raw button plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      start_meta_q <= start_btn;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
    end
  end

  // Run-state sequencing and per-frame scheduling of scroll, respawn, score and speed
  always_comb begin
    state_d    = state_q;
    cacti_d    = cacti_q;
    speed_d    = speed_q;
    div_d      = div_q;
    lfsr_d     = lfsr_q;
    hold_d     = hold_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d    = RUN;
          score_clr  = 1'b1;
          div_d      = '0;
          new_high_d = 1'b0;
          speed_d    = SPD_INIT;
          cacti_d    = SPAWN_L;
        end
      end
      RUN: begin
        if (collision) begin
          // Collision wins over a coincident frame_tick; latch the high score on entry
          state_d = OVER;
          hold_d  = '0;
          if (score > high_q) begin
            high_d     = score;
            new_high_d = 1'b1;
          end else begin
            new_high_d = 1'b0;
          end
        end else if (frame_tick) begin
          if (cacti_q <= {7'b0, speed_q}) begin
            cacti_d = SPAWN_L + {3'b0, lfsr_q};
            lfsr_d  = lfsr7_step(lfsr_q);
          end else begin
            cacti_d = cacti_q - {7'b0, speed_q};
          end
          if (div_q == DIV_LAST) begin
            div_d     = '0;
            score_inc = 1'b1;
            if (score_carry && (speed_q < SPD_MAX)) speed_d = speed_q + 3'd1;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      OVER: begin
        if (start_pulse && (hold_q >= HOLD_L)) begin
          state_d    = RUN;
          score_clr  = 1'b1;
          div_d      = '0;
          new_high_d = 1'b0;
          speed_d    = SPD_INIT;
          cacti_d    = SPAWN_L;
        end else if (frame_tick && (hold_q < HOLD_L)) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also clears the high score and reloads the LFSR seed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cacti_q    <= SPAWN_L;
      speed_q    <= SPD_INIT;
      div_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      hold_q     <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cacti_q    <= cacti_d;
      speed_q    <= speed_d;
      div_q      <= div_d;
      lfsr_q     <= lfsr_d;
      hold_q     <= hold_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  assign game_on   = (state_q == RUN);
  assign game_over = (state_q == OVER);
  assign cacti_x   = cacti_q;
  assign score_bcd = score;
  assign high_bcd  = high_q;
  assign new_high  = new_high_q;
  assign speed     = speed_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized self-checking bench for game_sequencer against a frame-level model
module tb_game_sequencer;

  localparam int SCORE_DIV = 1;
  localparam int HOLD      = 30;
  localparam int SPAWN     = 640;
  localparam int SPD_MAX   = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick, start_btn, collision;
  logic        game_on, game_over, new_high;
  logic [9:0]  cacti_x;
  logic [19:0] score_bcd, high_bcd;
  logic [2:0]  speed;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: 0 idle, 1 run, 2 over; score and high kept as plain integers
  int m_st, m_x, m_score, m_high, m_nh, m_spd, m_div, m_lfsr, m_hold;
  bit h1, h2, h3, m_pulse;

  game_sequencer #(.SCORE_DIV(SCORE_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .collision  (collision),
    .game_on    (game_on),
    .game_over  (game_over),
    .cacti_x    (cacti_x),
    .score_bcd  (score_bcd),
    .high_bcd   (high_bcd),
    .new_high   (new_high),
    .speed      (speed)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int d;
    r = '0;
    d = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, advanced once per clock from the rules of the game
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = 0; m_x = SPAWN; m_score = 0; m_high = 0; m_nh = 0;
      m_spd = 1; m_div = 0; m_lfsr = 'h5A; m_hold = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      m_pulse = h2 && !h3;
      h3 = h2; h2 = h1; h1 = start_btn;
      case (m_st)
        0: if (m_pulse) begin
             m_st = 1; m_score = 0; m_div = 0; m_nh = 0; m_spd = 1; m_x = SPAWN;
           end
        1: if (collision) begin
             m_st = 2; m_hold = 0;
             if (m_score > m_high) begin m_high = m_score; m_nh = 1; end
             else m_nh = 0;
           end else if (frame_tick) begin
             if (m_x <= m_spd) begin
               m_x = SPAWN + m_lfsr;
               m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1)) & 127;
             end else begin
               m_x = m_x - m_spd;
             end
             if (m_div == SCORE_DIV - 1) begin
               m_div = 0;
               if (m_score < 99999) begin
                 if (m_score % 100 == 99 && m_spd < SPD_MAX) m_spd = m_spd + 1;
                 m_score = m_score + 1;
               end
             end else begin
               m_div = m_div + 1;
             end
           end
        default: if (m_pulse && m_hold >= HOLD) begin
             m_st = 1; m_score = 0; m_div = 0; m_nh = 0; m_spd = 1; m_x = SPAWN;
           end else if (frame_tick && m_hold < HOLD) begin
             m_hold = m_hold + 1;
           end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("game_on",   32'(game_on),   32'(m_st == 1));
      chk("game_over", 32'(game_over), 32'(m_st == 2));
      chk("cacti_x",   32'(cacti_x),   32'(m_x));
      chk("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
      chk("high_bcd",  32'(high_bcd),  32'(to_bcd(m_high)));
      chk("new_high",  32'(new_high),  32'(m_nh));
      chk("speed",     32'(speed),     32'(m_spd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc();
      frame_tick = 1'b0; cyc(); cyc();
    end
  endtask

  task automatic press();
    start_btn = 1'b1;
    repeat (10) cyc();
    start_btn = 1'b0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; collision = 1'b0;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    chk_en = 1'b1;

    // Idle: frame ticks without start do nothing
    frames(5);
    chk("idle_game_on", 32'(game_on), 0);
    chk("idle_cacti", 32'(cacti_x), 640);
    chk("idle_score", 32'(score_bcd), 0);
    chk("idle_speed", 32'(speed), 1);

    // First run to 41, collision coincident with frame_tick
    press();
    chk("start_game_on", 32'(game_on), 1);
    frames(41);
    collision = 1'b1; frame_tick = 1'b1; cyc();
    collision = 1'b0; frame_tick = 1'b0;
    chk("over_flag", 32'(game_over), 1);
    chk("over_score", 32'(score_bcd), 32'h41);
    chk("over_high", 32'(high_bcd), 32'h41);
    chk("over_new_high", 32'(new_high), 1);
    chk("over_cacti", 32'(cacti_x), 599);

    // Hold: start after 10 frames ignored, after 31 frames accepted
    frames(10);
    press();
    chk("hold_ignored", 32'(game_over), 1);
    frames(21);
    press();
    chk("restart_game_on", 32'(game_on), 1);
    chk("restart_score", 32'(score_bcd), 0);
    chk("restart_speed", 32'(speed), 1);
    chk("restart_new_high", 32'(new_high), 0);
    chk("restart_high", 32'(high_bcd), 32'h41);

    // Speed ramp and first respawn from the seed
    frames(150);
    chk("f150_score", 32'(score_bcd), 32'h150);
    chk("f150_speed", 32'(speed), 2);
    chk("f150_cacti", 32'(cacti_x), 440);
    frames(160);
    chk("f310_cacti", 32'(cacti_x), 730);
    chk("f310_score", 32'(score_bcd), 32'h310);
    chk("f310_speed", 32'(speed), 4);
    collision = 1'b1; cyc(); collision = 1'b0;
    chk("over2_high", 32'(high_bcd), 32'h310);
    chk("over2_new_high", 32'(new_high), 1);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      frame_tick = ($urandom_range(2) == 0);
      collision  = ($urandom_range(249) == 0);
      if ($urandom_range(29) == 0) start_btn = ~start_btn;
      cyc();
    end
    frame_tick = 1'b0; collision = 1'b0; start_btn = 1'b0;
    repeat (4) cyc();

    // Saturation at 99999
    frames(35);
    press();
    chk("sat_game_on", 32'(game_on), 1);
    force dut.u_score.cnt_q = 20'h99999;
    m_score = 99999;
    #1;
    release dut.u_score.cnt_q;
    frames(2);
    chk("sat_score", 32'(score_bcd), 32'h99999);

    // Asynchronous reset mid-run
    frames(3);
    reset = 1'b1;
    #2;
    chk("rst_game_on", 32'(game_on), 0);
    chk("rst_game_over", 32'(game_over), 0);
    chk("rst_score", 32'(score_bcd), 0);
    chk("rst_high", 32'(high_bcd), 0);
    chk("rst_cacti", 32'(cacti_x), 640);
    chk("rst_speed", 32'(speed), 1);
    chk("rst_new_high", 32'(new_high), 0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
